// File: rtl/aes_decipher_block.sv
// Iterative AES inverse cipher: one InvShiftRows, four inverse S-box word
// lookups and one AddRoundKey/InvMixColumns step per round.
module aes_decipher_block #(
  parameter int unsigned AES128_ROUNDS = 10,
  parameter int unsigned AES256_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round_key_addr,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [2:0] {IDLE, INIT, SHIFT, SBOX, ADDKEY} state_t;

  state_t       st_q, st_d;
  logic [127:0] blk_q, blk_d;
  logic [3:0]   rc_q, rc_d;
  logic [1:0]   wc_q, wc_d;
  logic         rdy_q, rdy_d;
  logic [7:0]   sb [16];
  logic [127:0] shifted;
  logic [127:0] keyed;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] m0b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] m0d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] m0e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3),
            m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3),
            m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3),
            m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3)};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  // Byte i = column (i/4), row (i%4); row r of the result is rotated right by r.
  for (genvar i = 0; i < 16; i++) begin : g_bytes
    assign sb[i] = blk_q[127-8*i -: 8];
  end

  assign shifted = {sb[0],  sb[13], sb[10], sb[7],
                    sb[4],  sb[1],  sb[14], sb[11],
                    sb[8],  sb[5],  sb[2],  sb[15],
                    sb[12], sb[9],  sb[6],  sb[3]};

  assign keyed          = blk_q ^ round_key;
  assign round_key_addr = rc_q;
  assign new_block      = blk_q;
  assign ready          = rdy_q;

  always_comb begin
    sboxw = '0;
    case (wc_q)
      2'd0: sboxw = blk_q[127:96];
      2'd1: sboxw = blk_q[95:64];
      2'd2: sboxw = blk_q[63:32];
      2'd3: sboxw = blk_q[31:0];
      default: sboxw = '0;
    endcase
  end

  always_comb begin
    st_d  = st_q;
    blk_d = blk_q;
    rc_d  = rc_q;
    wc_d  = wc_q;
    rdy_d = rdy_q;
    case (st_q)
      IDLE: begin
        if (next) begin
          rdy_d = 1'b0;
          rc_d  = keylen ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);
          st_d  = INIT;
        end
      end
      INIT: begin
        blk_d = block ^ round_key;
        rc_d  = rc_q - 4'd1;
        st_d  = SHIFT;
      end
      SHIFT: begin
        blk_d = shifted;
        wc_d  = '0;
        st_d  = SBOX;
      end
      SBOX: begin
        case (wc_q)
          2'd0: blk_d[127:96] = new_sboxw;
          2'd1: blk_d[95:64]  = new_sboxw;
          2'd2: blk_d[63:32]  = new_sboxw;
          2'd3: blk_d[31:0]   = new_sboxw;
          default: blk_d = blk_q;
        endcase
        wc_d = wc_q + 2'd1;
        if (wc_q == 2'd3) st_d = ADDKEY;
      end
      ADDKEY: begin
        if (rc_q != 4'd0) begin
          blk_d = inv_mix(keyed);
          rc_d  = rc_q - 4'd1;
          st_d  = SHIFT;
        end else begin
          blk_d = keyed;
          rdy_d = 1'b1;
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= IDLE;
      blk_q <= '0;
      rc_q  <= '0;
      wc_q  <= '0;
      rdy_q <= 1'b1;
    end else begin
      st_q  <= st_d;
      blk_q <= blk_d;
      rc_q  <= rc_d;
      wc_q  <= wc_d;
      rdy_q <= rdy_d;
    end
  end

endmodule
